trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl_pkg.sv | 29 ++
 rtl/trap_prio.sv | 38 +++
 rtl/trap_ctrl.sv | 136 +++++++++++++
 tb/tb_trap_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared trap definitions: cause codes, interrupt flag position and FSM states.
package trap_ctrl_pkg;

  localparam logic [3:0] CAUSE_IMEM_MISALIGN  = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK         = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ECALL          = 4'd11;
  localparam logic [3:0] CAUSE_EXT_IRQ        = 4'd11;

  // trap_src[IRQ_BIT] set means the trap is an interrupt, not an exception
  localparam int IRQ_BIT = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRAP      = 3'd1,
    ST_MRET_WAIT = 3'd2,
    ST_REDIRECT  = 3'd3,
    ST_DRAIN     = 3'd4
  } state_e;

  // Data-misalignment causes are the only ones that report a faulting address
  function automatic logic is_misalign_src(input logic [4:0] src);
    return !src[IRQ_BIT] &&
           ((src[3:0] == CAUSE_LOAD_MISALIGN) || (src[3:0] == CAUSE_STORE_MISALIGN));
  endfunction

endpackage

// File: rtl/trap_prio.sv
// Trap cause selection: fixed-priority pick of the highest sync exception,
// falling back to the external interrupt when no exception is present.
module trap_prio
  import trap_ctrl_pkg::*;
(
  input  logic       imem_misalign,
  input  logic       illegal,
  input  logic       ebreak,
  input  logic       ecall,
  input  logic       dmem_misalign,
  input  logic       store,
  input  logic       irq,
  output logic       valid,
  output logic [4:0] trap_src
);

  // Priority chain, highest first; the interrupt only wins when nothing else does
  always_comb begin
    valid    = 1'b1;
    trap_src = 5'd0;
    if (imem_misalign) begin
      trap_src = {1'b0, CAUSE_IMEM_MISALIGN};
    end else if (illegal) begin
      trap_src = {1'b0, CAUSE_ILLEGAL};
    end else if (ebreak) begin
      trap_src = {1'b0, CAUSE_EBREAK};
    end else if (ecall) begin
      trap_src = {1'b0, CAUSE_ECALL};
    end else if (dmem_misalign) begin
      trap_src = {1'b0, store ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN};
    end else if (irq) begin
      trap_src = {1'b1, CAUSE_EXT_IRQ};
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap / mret sequencer: latches trap info, redirects fetch, then drains the
// pipeline for DRAIN_CYCLES cycles while ignoring execute-stage events.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | accepting execute-stage events
// ST_TRAP      | trap info latched, trap pulse to CSR side
// ST_MRET_WAIT | mret seen, waiting one cycle before redirecting to mepc
// ST_REDIRECT  | redirect + pipe_flush pulse to fetch
// ST_DRAIN     | ignoring execute events while the flushed pipe empties
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_imem_misalign,
  input  logic        ex_illegal,
  input  logic        ex_ebreak,
  input  logic        ex_ecall,
  input  logic        ex_mret,
  input  logic        ex_dmem_misalign,
  input  logic        ex_store,
  input  logic [31:0] ex_dmem_addr,
  input  logic        irq_ext,
  input  logic        irq_enable,
  input  logic [31:0] mtvec_rdata,
  input  logic [31:0] mepc_rdata,
  output logic        trap,
  output logic [4:0]  trap_src,
  output logic        misalign,
  output logic [31:0] pc,
  output logic [31:0] dmem_addr,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        pipe_flush,
  output logic        busy
);

  // Counter is loaded on the REDIRECT cycle and DRAIN exits when it hits zero,
  // so DRAIN lasts exactly DRAIN_CYCLES cycles.
  localparam logic [1:0] DRAIN_INIT = 2'(DRAIN_CYCLES - 1);

  state_e      state_q;
  state_e      state_d;
  logic [1:0]  drain_cnt_q;
  logic        prio_valid;
  logic [4:0]  prio_src;
  logic        trap_entry;

  trap_prio u_prio (
    .imem_misalign (ex_imem_misalign),
    .illegal       (ex_illegal),
    .ebreak        (ex_ebreak),
    .ecall         (ex_ecall),
    .dmem_misalign (ex_dmem_misalign),
    .store         (ex_store),
    .irq           (irq_ext & irq_enable),
    .valid         (prio_valid),
    .trap_src      (prio_src)
  );

  // Next-state logic; a trap always beats mret, so a trapping mret never redirects to mepc
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid && prio_valid) begin
          state_d = ST_TRAP;
        end else if (ex_valid && ex_mret) begin
          state_d = ST_MRET_WAIT;
        end
      end
      ST_TRAP:      state_d = ST_REDIRECT;
      ST_MRET_WAIT: state_d = ST_REDIRECT;
      ST_REDIRECT:  state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (drain_cnt_q == 2'd0) begin
          state_d = ST_IDLE;
        end
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  assign trap_entry = (state_q == ST_IDLE) && (state_d == ST_TRAP);

  // State register and drain down-counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= 2'd0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_REDIRECT) begin
        drain_cnt_q <= DRAIN_INIT;
      end else if ((state_q == ST_DRAIN) && (drain_cnt_q != 2'd0)) begin
        drain_cnt_q <= drain_cnt_q - 2'd1;
      end
    end
  end

  // Registered outputs, decoded from the next state so they line up with the state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap        <= 1'b0;
      redirect    <= 1'b0;
      pipe_flush  <= 1'b0;
      busy        <= 1'b0;
      trap_src    <= 5'd0;
      misalign    <= 1'b0;
      pc          <= 32'd0;
      dmem_addr   <= 32'd0;
      redirect_pc <= 32'd0;
    end else begin
      trap       <= (state_d == ST_TRAP);
      redirect   <= (state_d == ST_REDIRECT);
      pipe_flush <= (state_d == ST_REDIRECT);
      busy       <= (state_d != ST_IDLE);
      if (trap_entry) begin
        trap_src  <= prio_src;
        misalign  <= is_misalign_src(prio_src);
        pc        <= ex_pc;
        dmem_addr <= ex_dmem_addr;
      end
      if (state_d == ST_REDIRECT) begin
        redirect_pc <= (state_q == ST_TRAP) ? (mtvec_rdata & ~32'h3)
                                            : (mepc_rdata & ~32'h3);
      end
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a timeline model.
module tb_trap_ctrl;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid, ex_imem_misalign, ex_illegal, ex_ebreak, ex_ecall, ex_mret;
  logic        ex_dmem_misalign, ex_store, irq_ext, irq_enable;
  logic [31:0] ex_pc, ex_dmem_addr, mtvec_rdata, mepc_rdata;
  logic        trap, misalign, redirect, pipe_flush, busy;
  logic [4:0]  trap_src;
  logic [31:0] pc, dmem_addr, redirect_pc;

  trap_ctrl #(.DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_imem_misalign(ex_imem_misalign), .ex_illegal(ex_illegal),
    .ex_ebreak(ex_ebreak), .ex_ecall(ex_ecall), .ex_mret(ex_mret),
    .ex_dmem_misalign(ex_dmem_misalign), .ex_store(ex_store),
    .ex_dmem_addr(ex_dmem_addr),
    .irq_ext(irq_ext), .irq_enable(irq_enable),
    .mtvec_rdata(mtvec_rdata), .mepc_rdata(mepc_rdata),
    .trap(trap), .trap_src(trap_src), .misalign(misalign), .pc(pc),
    .dmem_addr(dmem_addr), .redirect(redirect), .redirect_pc(redirect_pc),
    .pipe_flush(pipe_flush), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_n counts cycles since an event was accepted (0 = idle). Event cycle+1 is the
  // trap/mret-wait cycle, +2 the redirect cycle, +3..+2+D drain, then idle again.
  int          m_n = 0;
  bit          m_is_trap = 1'b0;
  logic [4:0]  m_src = '0;
  logic [31:0] m_pc = '0, m_daddr = '0, m_rpc = '0;
  bit          m_mis = 1'b0;

  // {taken, trap_src}: highest-priority cause, interrupt last
  function automatic logic [5:0] ref_cause();
    if (ex_imem_misalign)       return {1'b1, 5'd0};
    if (ex_illegal)             return {1'b1, 5'd2};
    if (ex_ebreak)              return {1'b1, 5'd3};
    if (ex_ecall)               return {1'b1, 5'd11};
    if (ex_dmem_misalign)       return {1'b1, ex_store ? 5'd6 : 5'd4};
    if (irq_ext && irq_enable)  return {1'b1, 5'd27};
    return 6'd0;
  endfunction

  initial begin
    logic [5:0] c;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_n = 0; m_is_trap = 1'b0; m_src = '0; m_pc = '0; m_daddr = '0; m_rpc = '0; m_mis = 1'b0;
      end else if (m_n != 0) begin
        m_n++;
        if (m_n == 2) m_rpc = (m_is_trap ? mtvec_rdata : mepc_rdata) & 32'hFFFF_FFFC;
        if (m_n > 2 + D) m_n = 0;
      end else if (ex_valid) begin
        c = ref_cause();
        if (c[5]) begin
          m_n = 1; m_is_trap = 1'b1; m_src = c[4:0];
          m_pc = ex_pc; m_daddr = ex_dmem_addr;
          m_mis = (c[4:0] == 5'd4) || (c[4:0] == 5'd6);
        end else if (ex_mret) begin
          m_n = 1; m_is_trap = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_trap",        32'(trap),        32'(m_is_trap && m_n == 1));
      chk("m_redirect",    32'(redirect),    32'(m_n == 2));
      chk("m_pipe_flush",  32'(pipe_flush),  32'(m_n == 2));
      chk("m_busy",        32'(busy),        32'(m_n != 0));
      chk("m_trap_src",    32'(trap_src),    32'(m_src));
      chk("m_misalign",    32'(misalign),    32'(m_mis));
      chk("m_pc",          pc,               m_pc);
      chk("m_dmem_addr",   dmem_addr,        m_daddr);
      chk("m_redirect_pc", redirect_pc,      m_rpc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clr_ex();
    ex_valid = 0; ex_imem_misalign = 0; ex_illegal = 0; ex_ebreak = 0; ex_ecall = 0;
    ex_mret = 0; ex_dmem_misalign = 0; ex_store = 0; ex_pc = '0; ex_dmem_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 30) begin
      tick();
      k++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle busy still 1 after %0d cycles, required 0", k);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_trap"},     32'(trap),       32'd0);
    chk({tag, "_redirect"}, 32'(redirect),   32'd0);
    chk({tag, "_flush"},    32'(pipe_flush), 32'd0);
    chk({tag, "_busy"},     32'(busy),       32'd0);
    chk({tag, "_src"},      32'(trap_src),   32'd0);
    chk({tag, "_mis"},      32'(misalign),   32'd0);
    chk({tag, "_pc"},       pc,              32'd0);
    chk({tag, "_daddr"},    dmem_addr,       32'd0);
    chk({tag, "_rpc"},      redirect_pc,     32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int busy_cnt;
    int k;
    clr_ex();
    irq_ext = 0; irq_enable = 0; mtvec_rdata = '0; mepc_rdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    chk_en = 1'b1;

    // ecall -> trap 0x0B, then redirect to aligned mtvec
    ex_valid = 1; ex_ecall = 1; ex_pc = 32'h100; mtvec_rdata = 32'h8000_0003;
    tick();
    chk("ecall_trap", 32'(trap), 32'd1);
    chk("ecall_src", 32'(trap_src), 32'h0B);
    chk("ecall_pc", pc, 32'h100);
    chk("ecall_busy", 32'(busy), 32'd1);
    chk("ecall_noredir", 32'(redirect), 32'd0);
    clr_ex();
    tick();
    chk("ecall_redirect", 32'(redirect), 32'd1);
    chk("ecall_rpc", redirect_pc, 32'h8000_0000);
    chk("ecall_flush", 32'(pipe_flush), 32'd1);
    chk("ecall_trap_once", 32'(trap), 32'd0);
    wait_idle();

    // illegal beats ecall and interrupt
    ex_valid = 1; ex_illegal = 1; ex_ecall = 1; irq_ext = 1; irq_enable = 1; ex_pc = 32'h140;
    tick();
    chk("prio_trap", 32'(trap), 32'd1);
    chk("prio_src", 32'(trap_src), 32'h02);
    clr_ex(); irq_ext = 0; irq_enable = 0;
    wait_idle();

    // misaligned store then load
    ex_valid = 1; ex_dmem_misalign = 1; ex_store = 1; ex_dmem_addr = 32'h1003; ex_pc = 32'h180;
    tick();
    chk("st_src", 32'(trap_src), 32'h06);
    chk("st_mis", 32'(misalign), 32'd1);
    chk("st_daddr", dmem_addr, 32'h1003);
    clr_ex();
    wait_idle();
    ex_valid = 1; ex_dmem_misalign = 1; ex_store = 0; ex_dmem_addr = 32'h1003; ex_pc = 32'h184;
    tick();
    chk("ld_src", 32'(trap_src), 32'h04);
    chk("ld_mis", 32'(misalign), 32'd1);
    clr_ex();
    wait_idle();

    // mret: no trap, redirect to mepc two cycles after mret is presented
    mepc_rdata = 32'h204;
    ex_valid = 1; ex_mret = 1;
    tick();
    chk("mret_notrap", 32'(trap), 32'd0);
    chk("mret_busy", 32'(busy), 32'd1);
    chk("mret_noredir_early", 32'(redirect), 32'd0);
    busy_cnt = 1;
    clr_ex();
    tick();
    chk("mret_redirect", 32'(redirect), 32'd1);
    chk("mret_rpc", redirect_pc, 32'h204);
    if (busy) busy_cnt++;
    k = 0;
    while (busy && k < 30) begin
      tick();
      if (busy) busy_cnt++;
      k++;
    end
    chk("mret_busy_len", 32'(busy_cnt), 32'(2 + D));

    // interrupt gated by enable, then taken in IDLE
    ex_valid = 1; ex_pc = 32'h300; irq_ext = 1; irq_enable = 0;
    repeat (3) begin
      tick();
      chk("irq_off_trap", 32'(trap), 32'd0);
      chk("irq_off_busy", 32'(busy), 32'd0);
    end
    irq_enable = 1;
    tick();
    chk("irq_trap", 32'(trap), 32'd1);
    chk("irq_src", 32'(trap_src), 32'h1B);
    chk("irq_pc", pc, 32'h300);
    clr_ex(); irq_ext = 0; irq_enable = 0;
    wait_idle();

    // ecall during DRAIN is dropped
    ex_valid = 1; ex_ecall = 1; ex_pc = 32'h400; mtvec_rdata = 32'h1000;
    tick();
    clr_ex();
    tick();
    ex_valid = 1; ex_ecall = 1; ex_pc = 32'h500;
    repeat (D) begin
      tick();
      chk("drain_trap", 32'(trap), 32'd0);
      chk("drain_busy", 32'(busy), 32'd1);
    end
    clr_ex();
    tick();
    chk("drain_idle", 32'(busy), 32'd0);
    chk("drain_pc_kept", pc, 32'h400);

    // reset during REDIRECT, then an event on the first edge after release
    ex_valid = 1; ex_ecall = 1; ex_pc = 32'h440;
    tick();
    clr_ex();
    tick();
    chk("rst_pre_redirect", 32'(redirect), 32'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    tick();
    rst = 1'b0;
    ex_valid = 1; ex_ecall = 1; ex_pc = 32'h600;
    tick();
    chk("post_rst_trap", 32'(trap), 32'd1);
    chk("post_rst_pc", pc, 32'h600);
    clr_ex();
    wait_idle();

    // randomized run against the model
    for (int i = 0; i < 2000; i++) begin
      ex_valid         = ($urandom_range(0, 3) != 0);
      ex_imem_misalign = ($urandom_range(0, 11) == 0);
      ex_illegal       = ($urandom_range(0, 9) == 0);
      ex_ebreak        = ($urandom_range(0, 9) == 0);
      ex_ecall         = ($urandom_range(0, 9) == 0);
      ex_dmem_misalign = ($urandom_range(0, 7) == 0);
      ex_store         = ($urandom_range(0, 1) == 0);
      ex_mret          = ($urandom_range(0, 5) == 0);
      irq_ext          = ($urandom_range(0, 3) == 0);
      irq_enable       = ($urandom_range(0, 1) == 0);
      ex_pc            = $urandom;
      ex_dmem_addr     = $urandom;
      mtvec_rdata      = $urandom;
      mepc_rdata       = $urandom;
      rst              = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    clr_ex(); irq_ext = 0; irq_enable = 0;
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
